// File: rtl/uart_dump_tx.sv
// uart_dump_tx: reads words from a sync memory port and sends them as 8N1 bytes, little-endian.
// Define DUMP_CHECKSUM_EN to append a two's-complement checksum byte after the last word.
module uart_dump_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic [31:0]       mem_dat,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int RW = ADDR_W + 1;
    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT, START, DATA, STOP, NEXT,
`ifdef DUMP_CHECKSUM_EN
        CSUM,
`endif
        FINISH
    } state_t;
    state_t state, state_n;
    logic [CW-1:0] baud;
    logic [2:0] bit_idx;
    logic [1:0] byte_idx;
    logic [ADDR_W-1:0] addr;
    logic [RW-1:0] remaining;
    logic [31:0] shift;
    logic tick, bit_state, last_word;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0] csum;
    logic csum_phase;
`else
    localparam logic csum_phase = 1'b0;
`endif
    assign bit_state = state == START || state == DATA || state == STOP;
    assign tick      = baud == CW'(CLKS_PER_BIT - 1);
    assign last_word = remaining == RW'(1);
    assign mem_rd    = state == FETCH;
    assign mem_adr   = addr;
    assign busy      = state != IDLE;
    assign done      = state == FINISH;
    assign tx        = state == START ? 1'b0 : state == DATA ? shift[bit_idx] : 1'b1;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   state_n = !start ? IDLE : word_count == '0 ? FINISH : FETCH;
            FETCH:  state_n = WAIT;
            WAIT:   state_n = START;
            START:  state_n = tick ? DATA : START;
            DATA:   state_n = tick && bit_idx == 3'd7 ? STOP : DATA;
            STOP:   state_n = tick ? NEXT : STOP;
`ifdef DUMP_CHECKSUM_EN
            NEXT:   state_n = byte_idx != 2'd3 ? START : csum_phase ? FINISH : !last_word ? FETCH : CSUM;
            CSUM:   state_n = START;
`else
            NEXT:   state_n = byte_idx != 2'd3 ? START : csum_phase ? FINISH : !last_word ? FETCH : FINISH;
`endif
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            addr      <= '0;
            remaining <= '0;
            shift     <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            state <= state_n;
            // every entry into START/DATA/STOP sees a cleared baud counter
            baud  <= bit_state && !tick ? baud + 1'b1 : '0;
            case (state)
                IDLE: if (start) begin
                    addr      <= base_addr;
                    remaining <= word_count;
                    byte_idx  <= '0;
                    bit_idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
                    csum       <= '0;
                    csum_phase <= 1'b0;
`endif
                end
                WAIT: begin
                    shift    <= mem_dat;
                    byte_idx <= '0;
                end
                DATA: if (tick) bit_idx <= bit_idx + 1'b1;
`ifdef DUMP_CHECKSUM_EN
                STOP: if (tick) csum <= csum + shift[7:0];
                CSUM: begin
                    shift      <= {24'd0, ~csum + 8'd1};
                    csum_phase <= 1'b1;
                end
`endif
                NEXT: if (byte_idx != 2'd3) begin
                    shift    <= shift >> 8;
                    byte_idx <= byte_idx + 1'b1;
                end else if (!csum_phase) begin
                    remaining <= remaining - 1'b1;
                    addr      <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_dump_tx.sv
// tb_uart_dump_tx: table, directed and random dumps checked against a byte-stream model and a UART decoder.
module tb_uart_dump_tx;
    localparam int CPB = 4;
    localparam int AW  = 14;
`ifdef DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int BYTE_CYC = 10 * CPB + 1;
    logic clk = 0, rst = 1, start = 0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0] word_count = '0;
    logic mem_rd, tx, busy, done;
    logic [AW-1:0] mem_adr;
    logic [31:0] mem_dat = '0;
    logic [31:0] mem [0:(1<<AW)-1];

    uart_dump_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .mem_rd(mem_rd), .mem_adr(mem_adr), .mem_dat(mem_dat), .tx(tx), .busy(busy), .done(done));

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd) mem_dat <= mem[mem_adr];

    int done_cnt = 0, busy_cnt = 0, txlow_cnt = 0, ferr = 0;
    logic [AW-1:0] rd_q[$];
    logic [7:0] rx_q[$];
    bit rx_act = 0;
    int rx_idx = 0;
    logic [7:0] rx_b = '0;

    // mid-cycle monitor and a UART receiver sampling the middle of each 4-cycle bit
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        if (!tx) txlow_cnt++;
        if (mem_rd) rd_q.push_back(mem_adr);
        if (rst) rx_act = 0;
        else if (!rx_act) begin
            if (!tx) begin rx_act = 1; rx_idx = 0; end
        end else begin
            rx_idx++;
            if (rx_idx < CPB && tx) ferr++;
            if (rx_idx >= 6 && rx_idx <= 34 && (rx_idx - 6) % 4 == 0) rx_b = {tx, rx_b[7:1]};
            if (rx_idx == 38) begin
                if (!tx) ferr++;
                rx_q.push_back(rx_b);
                rx_act = 0;
            end
        end
    end

    int tests = 0, fails = 0;
    int rd0, rx0, done0, busy0, low0, ferr0;

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic snap;
        rd0 = rd_q.size(); rx0 = rx_q.size(); done0 = done_cnt;
        busy0 = busy_cnt; low0 = txlow_cnt; ferr0 = ferr;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] w);
        tick();
        start = 1; base_addr = b; word_count = w;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic run_dump(input logic [AW-1:0] b, input logic [AW:0] w);
        int t;
        snap();
        pulse_start(b, w);
        t = 0;
        while (done_cnt == done0 && t < 3000) begin tick(); t++; end
        repeat (5) tick();
    endtask

    function automatic int exp_busy(input int w);
        return w == 0 ? 1 : w * (2 + 4 * BYTE_CYC) + 1 + CS * (BYTE_CYC + 1);
    endfunction

    // expected reads and byte stream derived directly from memory contents
    task automatic check_model(input logic [AW-1:0] b, input logic [AW:0] w, input string tag);
        logic [7:0] eb[$];
        logic [AW-1:0] ea[$];
        logic [7:0] s, by;
        logic [AW-1:0] a;
        s = 0;
        for (int i = 0; i < int'(w); i++) begin
            a = b + AW'(i);
            ea.push_back(a);
            for (int k = 0; k < 4; k++) begin
                by = 8'(mem[a] >> (8 * k));
                eb.push_back(by);
                s += by;
            end
        end
        if (CS == 1 && w != 0) eb.push_back(8'd0 - s);
        check({tag, "_nreads"}, rd_q.size() - rd0, ea.size());
        for (int i = 0; i < ea.size() && rd0 + i < rd_q.size(); i++)
            check($sformatf("%s_adr%0d", tag, i), rd_q[rd0 + i], ea[i]);
        check({tag, "_nbytes"}, rx_q.size() - rx0, eb.size());
        for (int i = 0; i < eb.size() && rx0 + i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), rx_q[rx0 + i], eb[i]);
        check({tag, "_done"}, done_cnt - done0, 1);
        check({tag, "_frame"}, ferr - ferr0, 0);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   wc;
        logic [31:0]   d0, d1, d2;
        int            busy_cyc;
        int            nbytes;
        logic [7:0]    b0, last;
    } vec_t;
    vec_t vt[4];

    initial begin
        vt[0] = '{14'h0010, 15'd1, 32'h12345678, 32'h0, 32'h0, 167 + 42 * CS, 4 + CS, 8'h78, CS ? 8'hEC : 8'h12};
        vt[1] = '{14'h3FFF, 15'd3, 32'hA, 32'hB, 32'hC, 499 + 42 * CS, 12 + CS, 8'h0A, CS ? 8'hDF : 8'h00};
        vt[2] = '{14'h0100, 15'd0, 32'h0, 32'h0, 32'h0, 1, 0, 8'h00, 8'h00};
        vt[3] = '{14'h0200, 15'd1, 32'h01020304, 32'h0, 32'h0, 167 + 42 * CS, 4 + CS, 8'h04, CS ? 8'hF6 : 8'h01};
        #2;
        check("rst_tx", tx, 1);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_adr", mem_adr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        rst = 0;
        tick();

        foreach (vt[i]) begin
            mem[vt[i].base]          = vt[i].d0;
            mem[vt[i].base + 14'd1]  = vt[i].d1;
            mem[vt[i].base + 14'd2]  = vt[i].d2;
            run_dump(vt[i].base, vt[i].wc);
            check_model(vt[i].base, vt[i].wc, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_busy", i), busy_cnt - busy0, vt[i].busy_cyc);
            check($sformatf("vec%0d_cnt", i), rx_q.size() - rx0, vt[i].nbytes);
            check($sformatf("vec%0d_txlow", i), txlow_cnt - low0 == 0, vt[i].wc == 0);
            if (vt[i].nbytes > 0 && rx_q.size() > rx0) begin
                check($sformatf("vec%0d_b0", i), rx_q[rx0], vt[i].b0);
                check($sformatf("vec%0d_last", i), rx_q[rx_q.size() - 1], vt[i].last);
            end
        end

        // start latency, then a second start during byte 2 must be ignored
        mem[14'h20] = 32'hCAFEF00D;
        snap();
        pulse_start(14'h20, 1);
        tick();
        check("lat_mem_rd", mem_rd, 1);
        check("lat_adr", mem_adr, 14'h20);
        check("lat_busy", busy, 1);
        tick();
        check("lat_wait_rd", mem_rd, 0);
        check("lat_wait_tx", tx, 1);
        tick();
        check("lat_start_tx", tx, 0);
        repeat (47) tick();
        pulse_start(14'h100, 3);
        for (int t = 0; t < 3000 && done_cnt == done0; t++) tick();
        repeat (5) tick();
        check_model(14'h20, 1, "ign");
        check("ign_busy", busy_cnt - busy0, exp_busy(1));

        // start coincident with done is ignored
        snap();
        pulse_start(14'h40, 0);
        tick();
        check("coin_done", done, 1);
        start = 1; base_addr = 14'h50; word_count = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (5) tick();
        check("coin_busy", busy_cnt - busy0, 1);
        check("coin_reads", rd_q.size() - rd0, 0);
        check("coin_dones", done_cnt - done0, 1);

        // reset during DATA of byte 2
        mem[14'h60] = $urandom;
        snap();
        pulse_start(14'h60, 1);
        repeat (55) tick();
        rst = 1;
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        repeat (2) tick();
        rst = 0;
        repeat (3) tick();
        check("arst_nodone", done_cnt - done0, 0);
        check("arst_bytes", rx_q.size() - rx0, 1);
        if (rx_q.size() > rx0) check("arst_b0", rx_q[rx0], mem[14'h60][7:0]);
        run_dump(14'h60, 1);
        check_model(14'h60, 1, "after_rst");
        check("after_rst_busy", busy_cnt - busy0, exp_busy(1));

        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] b;
            logic [AW:0] w;
            b = AW'($urandom);
            w = (AW + 1)'($urandom_range(1, 3));
            for (int k = 0; k < 3; k++) mem[b + AW'(k)] = $urandom;
            run_dump(b, w);
            check_model(b, w, $sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_busy", r), busy_cnt - busy0, exp_busy(int'(w)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
